// File: rtl/bsg_cache_dma_arbiter.sv
// bsg_cache_dma_arbiter
//
// Shares one memory DMA channel among num_cache_p cache DMA ports. Packets
// are granted round-robin. The granted port then owns the data channel until
// a full block of block_size_in_words_p words has moved. Only one transaction
// is in flight at a time.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   dma_pkt_i/_v_i        per-cache DMA packets (slice i = port i); MSB is write_not_read
//   dma_pkt_yumi_o        per-cache packet accept
//   dma_data_o/_v_o       read data to caches (broadcast data, one-hot valid)
//   dma_data_ready_i      per-cache ready for read data
//   dma_data_i/_v_i       per-cache write-back data
//   dma_data_yumi_o       per-cache write-back accept
//   mem_dma_pkt_*         packet channel to shared memory
//   mem_dma_data_i/_v_i/_ready_o   read data from memory
//   mem_dma_data_o/_v_o/_yumi_i    write data to memory
//   owner_o               port currently holding the channel (0 when idle)
module bsg_cache_dma_arbiter #(
    parameter int num_cache_p           = 2,
    parameter int addr_width_p          = 30,
    parameter int data_width_p          = 64,
    parameter int block_size_in_words_p = 8
) (
    input  logic                                                           clk,
    input  logic                                                           reset,
    input  logic [num_cache_p*(1+addr_width_p+block_size_in_words_p)-1:0] dma_pkt_i,
    input  logic [num_cache_p-1:0]                                         dma_pkt_v_i,
    output logic [num_cache_p-1:0]                                         dma_pkt_yumi_o,
    output logic [num_cache_p*data_width_p-1:0]                            dma_data_o,
    output logic [num_cache_p-1:0]                                         dma_data_v_o,
    input  logic [num_cache_p-1:0]                                         dma_data_ready_i,
    input  logic [num_cache_p*data_width_p-1:0]                            dma_data_i,
    input  logic [num_cache_p-1:0]                                         dma_data_v_i,
    output logic [num_cache_p-1:0]                                         dma_data_yumi_o,
    output logic [1+addr_width_p+block_size_in_words_p-1:0]               mem_dma_pkt_o,
    output logic                                                           mem_dma_pkt_v_o,
    input  logic                                                           mem_dma_pkt_yumi_i,
    input  logic [data_width_p-1:0]                                        mem_dma_data_i,
    input  logic                                                           mem_dma_data_v_i,
    output logic                                                           mem_dma_data_ready_o,
    output logic [data_width_p-1:0]                                        mem_dma_data_o,
    output logic                                                           mem_dma_data_v_o,
    input  logic                                                           mem_dma_data_yumi_i,
    output logic [$clog2(num_cache_p)-1:0]                                 owner_o
);

    localparam int dma_pkt_width_lp = 1 + addr_width_p + block_size_in_words_p;
    localparam int lg_num_cache_lp  = $clog2(num_cache_p);
    localparam int lg_block_lp      = $clog2(block_size_in_words_p);

    typedef enum logic [1:0] {
        eIdle,
        eReadData,
        eWriteData
    } state_e;

    state_e                     state_q, state_d;
    logic [lg_num_cache_lp-1:0] rr_q, rr_d;
    logic [lg_num_cache_lp-1:0] owner_q, owner_d;
    logic [lg_block_lp-1:0]     count_q, count_d;

    logic [lg_num_cache_lp-1:0]  winner, winner_next;
    logic [lg_num_cache_lp-1:0]  idx_hi, idx_lo;
    logic                        found_hi;
    logic                        any_pkt_v;
    logic [dma_pkt_width_lp-1:0] winner_pkt;
    logic                        pkt_hs;
    logic                        read_xfer;
    logic                        write_xfer;
    logic                        last_word;

    // Round-robin pick: the lowest valid port at or above rr_q wins; if none
    // exists the search wraps, so the lowest valid port overall wins.
    always_comb begin
        found_hi = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int j = num_cache_p - 1; j >= 0; j--) begin
            if (dma_pkt_v_i[j]) begin
                idx_lo = j[lg_num_cache_lp-1:0];
                if (j >= int'(rr_q)) begin
                    found_hi = 1'b1;
                    idx_hi   = j[lg_num_cache_lp-1:0];
                end
            end
        end
        winner      = found_hi ? idx_hi : idx_lo;
        winner_next = (int'(winner) == num_cache_p - 1) ? '0 : winner + 1'b1;
    end

    assign any_pkt_v  = |dma_pkt_v_i;
    assign winner_pkt = dma_pkt_i[winner*dma_pkt_width_lp +: dma_pkt_width_lp];
    assign pkt_hs     = (state_q == eIdle) && any_pkt_v && mem_dma_pkt_yumi_i;
    assign read_xfer  = mem_dma_data_v_i && dma_data_ready_i[owner_q];
    assign write_xfer = dma_data_v_i[owner_q] && mem_dma_data_yumi_i;
    // The block size is a power of two, so the final word is the all-ones count.
    assign last_word  = &count_q;

    assign mem_dma_pkt_o  = winner_pkt;
    assign mem_dma_data_o = dma_data_i[owner_q*data_width_p +: data_width_p];
    assign dma_data_o     = {num_cache_p{mem_dma_data_i}};

    // State register; reset abandons any transaction in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= eIdle;
            rr_q    <= '0;
            owner_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: lock the owner on a packet handshake and count words
    // until the final word of the block has moved.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        count_d = count_q;
        case (state_q)
            eIdle: begin
                if (pkt_hs) begin
                    owner_d = winner;
                    rr_d    = winner_next;
                    count_d = '0;
                    state_d = winner_pkt[dma_pkt_width_lp-1] ? eWriteData : eReadData;
                end
            end
            eReadData: begin
                if (read_xfer) begin
                    count_d = count_q + 1'b1;
                    if (last_word) begin
                        state_d = eIdle;
                    end
                end
            end
            eWriteData: begin
                if (write_xfer) begin
                    count_d = count_q + 1'b1;
                    if (last_word) begin
                        state_d = eIdle;
                    end
                end
            end
            default: state_d = eIdle;
        endcase
    end

    // Handshake outputs are steered only to the owner (or to the winner while
    // idle). All of them are held low during reset, whatever the registered
    // state is.
    always_comb begin
        dma_pkt_yumi_o       = '0;
        mem_dma_pkt_v_o      = 1'b0;
        dma_data_v_o         = '0;
        dma_data_yumi_o      = '0;
        mem_dma_data_ready_o = 1'b0;
        mem_dma_data_v_o     = 1'b0;
        owner_o              = '0;
        if (!reset) begin
            case (state_q)
                eIdle: begin
                    mem_dma_pkt_v_o        = any_pkt_v;
                    dma_pkt_yumi_o[winner] = any_pkt_v && mem_dma_pkt_yumi_i;
                end
                eReadData: begin
                    owner_o               = owner_q;
                    dma_data_v_o[owner_q] = mem_dma_data_v_i;
                    mem_dma_data_ready_o  = dma_data_ready_i[owner_q];
                end
                eWriteData: begin
                    owner_o                  = owner_q;
                    mem_dma_data_v_o         = dma_data_v_i[owner_q];
                    dma_data_yumi_o[owner_q] = write_xfer;
                end
                default: begin
                    owner_o = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_cache_dma_arbiter.sv
// tb_bsg_cache_dma_arbiter
//
// Self-checking bench for bsg_cache_dma_arbiter with four ports and eight-word
// blocks. Directed scenarios come first. A randomized phase follows, which is
// checked against a transaction-level reference model.
module tb_bsg_cache_dma_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int BW = 8;
    localparam int PW = 1 + AW + BW;

    logic              clk = 1'b0;
    logic              reset;
    logic [N*PW-1:0]   dma_pkt_i;
    logic [N-1:0]      dma_pkt_v_i;
    logic [N-1:0]      dma_pkt_yumi_o;
    logic [N*DW-1:0]   dma_data_o;
    logic [N-1:0]      dma_data_v_o;
    logic [N-1:0]      dma_data_ready_i;
    logic [N*DW-1:0]   dma_data_i;
    logic [N-1:0]      dma_data_v_i;
    logic [N-1:0]      dma_data_yumi_o;
    logic [PW-1:0]     mem_dma_pkt_o;
    logic              mem_dma_pkt_v_o;
    logic              mem_dma_pkt_yumi_i;
    logic [DW-1:0]     mem_dma_data_i;
    logic              mem_dma_data_v_i;
    logic              mem_dma_data_ready_o;
    logic [DW-1:0]     mem_dma_data_o;
    logic              mem_dma_data_v_o;
    logic              mem_dma_data_yumi_i;
    logic [1:0]        owner_o;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state for the randomized phase.
    bit            pend [N];
    logic [PW-1:0] pktM [N];
    int            waitG [N];
    int            rdExp [N];
    int            rdGot [N];
    int            rrM, ownerM, wordM, txns, cyc;
    bit            busyM, writeM;

    always #5 clk = ~clk;

    bsg_cache_dma_arbiter #(
        .num_cache_p(N),
        .addr_width_p(AW),
        .data_width_p(DW),
        .block_size_in_words_p(BW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .dma_pkt_i(dma_pkt_i),
        .dma_pkt_v_i(dma_pkt_v_i),
        .dma_pkt_yumi_o(dma_pkt_yumi_o),
        .dma_data_o(dma_data_o),
        .dma_data_v_o(dma_data_v_o),
        .dma_data_ready_i(dma_data_ready_i),
        .dma_data_i(dma_data_i),
        .dma_data_v_i(dma_data_v_i),
        .dma_data_yumi_o(dma_data_yumi_o),
        .mem_dma_pkt_o(mem_dma_pkt_o),
        .mem_dma_pkt_v_o(mem_dma_pkt_v_o),
        .mem_dma_pkt_yumi_i(mem_dma_pkt_yumi_i),
        .mem_dma_data_i(mem_dma_data_i),
        .mem_dma_data_v_i(mem_dma_data_v_i),
        .mem_dma_data_ready_o(mem_dma_data_ready_o),
        .mem_dma_data_o(mem_dma_data_o),
        .mem_dma_data_v_o(mem_dma_data_v_o),
        .mem_dma_data_yumi_i(mem_dma_data_yumi_i),
        .owner_o(owner_o)
    );

    function automatic logic [PW-1:0] makePkt(input logic wr, input logic [AW-1:0] addr);
        return {wr, addr, {BW{1'b1}}};
    endfunction

    function automatic logic [DW-1:0] wordOf(input int p, input int w);
        return {8'(p), 8'(txns), 16'(w)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clearInputs();
        dma_pkt_i           = '0;
        dma_pkt_v_i         = '0;
        dma_data_ready_i    = '1;
        dma_data_i          = '0;
        dma_data_v_i        = '0;
        mem_dma_pkt_yumi_i  = 1'b0;
        mem_dma_data_i      = '0;
        mem_dma_data_v_i    = 1'b0;
        mem_dma_data_yumi_i = 1'b0;
    endtask

    task automatic applyReset();
        clearInputs();
        reset = 1'b1;
        nextCycle();
        nextCycle();
        reset = 1'b0;
    endtask

    task automatic checkAllQuiet(input string tag);
        checkOutput({tag, "_pkt_yumi"}, dma_pkt_yumi_o, 0);
        checkOutput({tag, "_pkt_v"}, mem_dma_pkt_v_o, 0);
        checkOutput({tag, "_data_v"}, dma_data_v_o, 0);
        checkOutput({tag, "_data_yumi"}, dma_data_yumi_o, 0);
        checkOutput({tag, "_mem_ready"}, mem_dma_data_ready_o, 0);
        checkOutput({tag, "_mem_v"}, mem_dma_data_v_o, 0);
        checkOutput({tag, "_owner"}, owner_o, 0);
    endtask

    // Present one packet alone on a port and expect it to be accepted at once.
    task automatic issuePkt(input int port, input logic wr, input logic [AW-1:0] addr);
        logic [PW-1:0] pkt;
        pkt = makePkt(wr, addr);
        dma_pkt_i[port*PW +: PW] = pkt;
        dma_pkt_v_i = '0;
        dma_pkt_v_i[port] = 1'b1;
        mem_dma_pkt_yumi_i = 1'b1;
        settle();
        checkOutput("issue_pkt_v", mem_dma_pkt_v_o, 1);
        checkOutput("issue_pkt_yumi", dma_pkt_yumi_o, 1 << port);
        checkOutput("issue_pkt_out", mem_dma_pkt_o, pkt);
        nextCycle();
        dma_pkt_v_i = '0;
        mem_dma_pkt_yumi_i = 1'b0;
    endtask

    // Memory streams a block of consecutive words with no stalls.
    task automatic runRead(input int port, input logic [DW-1:0] base);
        for (int k = 0; k < BW; k++) begin
            mem_dma_data_v_i = 1'b1;
            mem_dma_data_i   = base + DW'(k);
            settle();
            checkOutput("rd_v", dma_data_v_o, 1 << port);
            checkOutput("rd_data", dma_data_o[port*DW +: DW], base + DW'(k));
            checkOutput("rd_owner", owner_o, port);
            checkOutput("rd_no_pkt_v", mem_dma_pkt_v_o, 0);
            checkOutput("rd_no_pkt_yumi", dma_pkt_yumi_o, 0);
            nextCycle();
        end
        mem_dma_data_v_i = 1'b0;
    endtask

    // Drive one cycle of random traffic. Ports hold packet valid until accepted.
    task automatic applyStimulus();
        for (int p = 0; p < N; p++) begin
            if (!pend[p] && ($urandom_range(2) == 0)) begin
                pend[p] = 1'b1;
                pktM[p] = makePkt(1'($urandom_range(1)), AW'($urandom));
            end
            dma_pkt_i[p*PW +: PW] = pktM[p];
            dma_pkt_v_i[p]        = pend[p];
            dma_data_ready_i[p]   = ($urandom_range(3) != 0);
            dma_data_v_i[p]       = ($urandom_range(3) != 0);
            dma_data_i[p*DW +: DW] = (busyM && writeM && ownerM == p) ? wordOf(p, wordM) : DW'($urandom);
        end
        mem_dma_pkt_yumi_i  = 1'($urandom_range(1));
        mem_dma_data_v_i    = ($urandom_range(3) != 0);
        mem_dma_data_i      = DW'($urandom);
        mem_dma_data_yumi_i = 1'($urandom_range(1));
    endtask

    initial begin
        int   c;
        int   got;
        int   w;
        int   yumiCount;
        int   q;
        int   win;
        bit   found;
        bit   expPktV;
        bit   expReady;
        bit   expMemV;
        bit   xfer;
        int   expPktYumi;
        int   expDataV;
        int   expDYumi;
        int   expOwner;
        logic [PW-1:0] pkt0;
        logic [PW-1:0] pkt1;

        // Reset with every input active: all handshake outputs must stay low.
        clearInputs();
        reset = 1'b1;
        dma_pkt_v_i         = '1;
        mem_dma_pkt_yumi_i  = 1'b1;
        dma_data_v_i        = '1;
        mem_dma_data_v_i    = 1'b1;
        mem_dma_data_yumi_i = 1'b1;
        nextCycle();
        settle();
        checkAllQuiet("reset");
        clearInputs();
        reset = 1'b0;
        nextCycle();
        settle();
        checkAllQuiet("idle_after_reset");
        nextCycle();

        // A port-0 read of 0x10..0x17 reaches only port 0, then returns to idle.
        issuePkt(0, 1'b0, 16'h1234);
        runRead(0, 32'h10);
        mem_dma_data_v_i = 1'b1;
        settle();
        checkOutput("read_done_data_v", dma_data_v_o, 0);
        checkOutput("read_done_ready", mem_dma_data_ready_o, 0);
        checkOutput("read_done_owner", owner_o, 0);
        nextCycle();
        mem_dma_data_v_i = 1'b0;

        // Simultaneous requests: port 0 first, port 1 on the very next idle
        // cycle, then port 0 again.
        applyReset();
        pkt0 = makePkt(1'b0, 16'h0a00);
        pkt1 = makePkt(1'b0, 16'h0b00);
        dma_pkt_i[0*PW +: PW] = pkt0;
        dma_pkt_i[1*PW +: PW] = pkt1;
        dma_pkt_v_i = 4'b0011;
        mem_dma_pkt_yumi_i = 1'b1;
        settle();
        checkOutput("rr_first_yumi", dma_pkt_yumi_o, 4'b0001);
        checkOutput("rr_first_pkt", mem_dma_pkt_o, pkt0);
        nextCycle();
        dma_pkt_v_i = 4'b0010;
        runRead(0, 32'h20);
        settle();
        checkOutput("rr_second_yumi", dma_pkt_yumi_o, 4'b0010);
        checkOutput("rr_second_pkt", mem_dma_pkt_o, pkt1);
        nextCycle();
        dma_pkt_v_i = 4'b0000;
        runRead(1, 32'h30);
        dma_pkt_v_i = 4'b0011;
        settle();
        checkOutput("rr_third_yumi", dma_pkt_yumi_o, 4'b0001);
        nextCycle();
        dma_pkt_v_i = 4'b0000;
        mem_dma_pkt_yumi_i = 1'b0;
        runRead(0, 32'h50);

        // Port-1 write with its data valid every other cycle: 8 words in 16 cycles.
        issuePkt(1, 1'b1, 16'h0abc);
        w = 0;
        yumiCount = 0;
        mem_dma_data_yumi_i = 1'b1;
        dma_data_v_i[0] = 1'b1;
        dma_data_i[0*DW +: DW] = 32'hdead_beef;
        for (c = 0; c < 16; c++) begin
            dma_data_v_i[1] = (c % 2 == 1);
            dma_data_i[1*DW +: DW] = 32'h100 + DW'(w);
            settle();
            checkOutput("wr_mem_v", mem_dma_data_v_o, (c % 2 == 1));
            checkOutput("wr_yumi", dma_data_yumi_o, (c % 2 == 1) ? 4'b0010 : 4'b0000);
            if (c % 2 == 1) begin
                checkOutput("wr_mem_data", mem_dma_data_o, 32'h100 + DW'(w));
                w++;
            end
            yumiCount += int'(dma_data_yumi_o[1]);
            nextCycle();
        end
        checkOutput("wr_yumi_count", yumiCount, 8);
        dma_data_v_i[1] = 1'b1;
        settle();
        checkOutput("wr_done_mem_v", mem_dma_data_v_o, 0);
        checkOutput("wr_done_yumi", dma_data_yumi_o, 0);
        nextCycle();
        clearInputs();

        // Port-0 read with its ready low for five cycles mid-block.
        issuePkt(0, 1'b0, 16'h0200);
        got = 0;
        for (c = 0; (got < BW) && (c < 30); c++) begin
            dma_data_ready_i[0] = !((c >= 3) && (c < 8));
            mem_dma_data_v_i = 1'b1;
            mem_dma_data_i = 32'h40 + DW'(got);
            settle();
            checkOutput("stall_ready", mem_dma_data_ready_o, dma_data_ready_i[0]);
            checkOutput("stall_data_v", dma_data_v_o, 4'b0001);
            if (dma_data_ready_i[0]) begin
                checkOutput("stall_data", dma_data_o[0*DW +: DW], 32'h40 + DW'(got));
                got++;
            end
            nextCycle();
        end
        checkOutput("stall_words", got, BW);
        checkOutput("stall_cycles", c, 13);
        settle();
        checkOutput("stall_done_data_v", dma_data_v_o, 0);
        checkOutput("stall_done_owner", owner_o, 0);
        nextCycle();
        clearInputs();

        // Reset three words into a port-0 write; the block must be abandoned.
        issuePkt(0, 1'b1, 16'h0300);
        mem_dma_data_yumi_i = 1'b1;
        dma_data_v_i[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dma_data_i[0*DW +: DW] = 32'h200 + DW'(k);
            settle();
            checkOutput("abort_mem_v", mem_dma_data_v_o, 1);
            checkOutput("abort_yumi", dma_data_yumi_o, 4'b0001);
            nextCycle();
        end
        reset = 1'b1;
        dma_pkt_v_i = 4'b1000;
        mem_dma_pkt_yumi_i = 1'b1;
        mem_dma_data_v_i = 1'b1;
        settle();
        checkAllQuiet("abort_reset");
        nextCycle();
        reset = 1'b0;
        dma_pkt_v_i = '0;
        mem_dma_pkt_yumi_i = 1'b0;
        mem_dma_data_v_i = 1'b0;
        settle();
        checkAllQuiet("abort_idle");
        nextCycle();
        // The pointer was reset to 0, so port 0 beats port 3.
        dma_data_v_i = '0;
        dma_pkt_i[0*PW +: PW] = makePkt(1'b0, 16'h0400);
        dma_pkt_i[3*PW +: PW] = makePkt(1'b0, 16'h0500);
        dma_pkt_v_i = 4'b1001;
        mem_dma_pkt_yumi_i = 1'b1;
        settle();
        checkOutput("post_reset_yumi", dma_pkt_yumi_o, 4'b0001);
        nextCycle();
        dma_pkt_v_i = 4'b1000;
        runRead(0, 32'h60);
        settle();
        checkOutput("post_reset_second_yumi", dma_pkt_yumi_o, 4'b1000);
        nextCycle();
        dma_pkt_v_i = '0;
        mem_dma_pkt_yumi_i = 1'b0;
        runRead(3, 32'h70);

        // Randomized traffic on all four ports against the reference model.
        applyReset();
        for (int p = 0; p < N; p++) begin
            pend[p]  = 1'b0;
            pktM[p]  = '0;
            waitG[p] = 0;
            rdExp[p] = 0;
            rdGot[p] = 0;
        end
        rrM = 0; busyM = 1'b0; writeM = 1'b0; ownerM = 0; wordM = 0; txns = 0; cyc = 0;
        while (((txns < 500) || busyM) && (cyc < 40000)) begin
            applyStimulus();
            settle();
            found = 1'b0;
            win = 0;
            for (int k = 0; k < N; k++) begin
                q = (rrM + k) % N;
                if (!found && pend[q]) begin
                    found = 1'b1;
                    win = q;
                end
            end
            expPktV    = !busyM && found;
            expPktYumi = (expPktV && mem_dma_pkt_yumi_i) ? (1 << win) : 0;
            expDataV   = (busyM && !writeM && mem_dma_data_v_i) ? (1 << ownerM) : 0;
            expReady   = busyM && !writeM && dma_data_ready_i[ownerM];
            expMemV    = busyM && writeM && dma_data_v_i[ownerM];
            expDYumi   = (expMemV && mem_dma_data_yumi_i) ? (1 << ownerM) : 0;
            expOwner   = busyM ? ownerM : 0;
            checkOutput("rnd_pkt_v", mem_dma_pkt_v_o, expPktV);
            checkOutput("rnd_pkt_yumi", dma_pkt_yumi_o, expPktYumi);
            checkOutput("rnd_data_v", dma_data_v_o, expDataV);
            checkOutput("rnd_mem_ready", mem_dma_data_ready_o, expReady);
            checkOutput("rnd_mem_v", mem_dma_data_v_o, expMemV);
            checkOutput("rnd_data_yumi", dma_data_yumi_o, expDYumi);
            checkOutput("rnd_owner", owner_o, expOwner);
            if (expPktV) checkOutput("rnd_pkt_out", mem_dma_pkt_o, pktM[win]);
            if (expMemV) checkOutput("rnd_mem_data", mem_dma_data_o, wordOf(ownerM, wordM));
            if (expDataV != 0) checkOutput("rnd_rd_data", dma_data_o[ownerM*DW +: DW], mem_dma_data_i);
            // Grants observed at the DUT: no waiting port may see N other grants first.
            for (int p = 0; p < N; p++) begin
                if (dma_pkt_yumi_o[p]) begin
                    checkOutput("rnd_starve", waitG[p] <= N - 1, 1);
                    waitG[p] = 0;
                    for (int o = 0; o < N; o++) begin
                        if (o != p && pend[o]) waitG[o]++;
                    end
                end
                rdGot[p] += int'(dma_data_v_o[p] & dma_data_ready_i[p]);
            end
            if (!busyM) begin
                if (expPktV && mem_dma_pkt_yumi_i) begin
                    busyM  = 1'b1;
                    ownerM = win;
                    writeM = pktM[win][PW-1];
                    wordM  = 0;
                    rrM    = (win + 1) % N;
                    pend[win] = 1'b0;
                    txns++;
                    if (!writeM) rdExp[win] += BW;
                end
            end else begin
                xfer = writeM ? (dma_data_v_i[ownerM] && mem_dma_data_yumi_i)
                              : (mem_dma_data_v_i && dma_data_ready_i[ownerM]);
                if (xfer) begin
                    wordM++;
                    if (wordM == BW) busyM = 1'b0;
                end
            end
            nextCycle();
            cyc++;
        end
        checkOutput("rnd_cycle_budget", cyc < 40000, 1);
        for (int p = 0; p < N; p++) begin
            checkOutput("rnd_read_words", rdGot[p], rdExp[p]);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
